adc_tx_scheduler: RTL and testbench

- Shares the single 4-byte UART response path between four data producers: AD9244 ch0 sample, AD9244 ch1 sample, FFT ch0 result, and FFT ch1 result.
- Round-robin arbitrates requests, then latches and frames the winner's data into DataTX_1..4.
- Pulses EnTxData to the UART TX framer and waits for completion, with a timeout.
- Sits between the ADC/FFT read logic and the UART transmitter, alongside the UART command controller.

---
 rtl/adc_tx_scheduler.sv | 177 +++++++++++++++++
 tb/tb_adc_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_tx_scheduler.sv
// adc_tx_scheduler: round-robin arbiter that frames one of four ADC/FFT payloads into the
// 4-byte UART response and handshakes with the TX framer. Define ADC_TX_STAT_EN for frame/timeout counters.
module adc_tx_scheduler #(
   parameter int unsigned TIMEOUT_CYC = 2_500_000,
   parameter int unsigned GAP_CYC     = 16,
   parameter int unsigned TO_W        = 22
) (
   input  logic        clk_50m,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  req,
   input  logic [13:0] Data_O_AD9244,
   input  logic [13:0] Data_O_AD9244_1,
   input  logic [27:0] Data_send_FFT,
   input  logic [27:0] Data_send_FFT_1,
   input  logic        tx_done,
   input  logic        err_clr,
   output logic [3:0]  ack,
   output logic [7:0]  DataTX_1,
   output logic [7:0]  DataTX_2,
   output logic [7:0]  DataTX_3,
   output logic [7:0]  DataTX_4,
   output logic        EnTxData,
   output logic        busy,
`ifdef ADC_TX_STAT_EN
   output logic [15:0] frame_cnt,
   output logic [7:0]  to_cnt,
`endif
   output logic        err_timeout
);

   localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
   localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
   localparam logic [TO_W-1:0]  TO_LAST_V  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST_V = GAP_W'(GAP_LAST);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP} state_t;

   state_t           state_q;
   logic [1:0]       rr_q;
   logic [3:0]       ack_q;
   logic [7:0]       tx1_q, tx2_q, tx3_q, tx4_q;
   logic             en_tx_q;
   logic             err_q;
   logic [TO_W-1:0]  wait_cnt_q;
   logic [GAP_W-1:0] gap_cnt_q;

   logic             grant_vld;
   logic [1:0]       grant_idx;
   logic [27:0]      payload;
   logic             wait_ok;
   logic             wait_to;

   // Scan from the highest offset down so the source nearest the pointer wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[rr_q + 2'(i)]) begin
            grant_vld = 1'b1;
            grant_idx = rr_q + 2'(i);
         end
      end
   end

   always_comb begin
      case (grant_idx)
         2'd0:    payload = {14'd0, Data_O_AD9244};
         2'd1:    payload = {14'd0, Data_O_AD9244_1};
         2'd2:    payload = Data_send_FFT;
         default: payload = Data_send_FFT_1;
      endcase
   end

   // A tx_done on the final count still counts as a delivered frame.
   assign wait_ok = (state_q == S_WAIT) && tx_done;
   assign wait_to = (state_q == S_WAIT) && !tx_done && (wait_cnt_q == TO_LAST_V);

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_q       <= 2'd0;
         ack_q      <= 4'd0;
         tx1_q      <= 8'd0;
         tx2_q      <= 8'd0;
         tx3_q      <= 8'd0;
         tx4_q      <= 8'd0;
         en_tx_q    <= 1'b0;
         err_q      <= 1'b0;
         wait_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         ack_q   <= 4'd0;
         en_tx_q <= 1'b0;
         if (err_clr) begin
            err_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               // Capture on the grant edge so ack and the frame bytes appear together in LOAD.
               if (en && grant_vld) begin
                  state_q <= S_LOAD;
                  ack_q   <= 4'b0001 << grant_idx;
                  rr_q    <= grant_idx + 2'd1;
                  tx1_q   <= {2'b10, grant_idx, payload[27:24]};
                  tx2_q   <= payload[23:16];
                  tx3_q   <= payload[15:8];
                  tx4_q   <= payload[7:0];
               end
            end
            S_LOAD: begin
               state_q <= S_SEND;
               en_tx_q <= 1'b1;
            end
            S_SEND: begin
               state_q    <= S_WAIT;
               wait_cnt_q <= '0;
            end
            S_WAIT: begin
               if (wait_ok || wait_to) begin
                  state_q   <= S_GAP;
                  gap_cnt_q <= '0;
                  if (wait_to) begin
                     err_q <= 1'b1;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + TO_W'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST_V) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef ADC_TX_STAT_EN
   logic [15:0] frame_cnt_q;
   logic [7:0]  to_cnt_q;

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         frame_cnt_q <= 16'd0;
         to_cnt_q    <= 8'd0;
      end else begin
         if (wait_ok) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (wait_to) begin
            if (to_cnt_q != 8'hFF) begin
               to_cnt_q <= to_cnt_q + 8'd1;
            end
         end else if (err_clr) begin
            to_cnt_q <= 8'd0;
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign to_cnt    = to_cnt_q;
`endif

   assign ack         = ack_q;
   assign DataTX_1    = tx1_q;
   assign DataTX_2    = tx2_q;
   assign DataTX_3    = tx3_q;
   assign DataTX_4    = tx4_q;
   assign EnTxData    = en_tx_q;
   assign busy        = (state_q != S_IDLE);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_adc_tx_scheduler.sv
// tb_adc_tx_scheduler: directed bench for adc_tx_scheduler with short timeout (100) and GAP_CYC=16.
// Expected frame bytes are hand-computed from the {2'b10, grant, payload} layout.
module tb_adc_tx_scheduler;

   localparam int unsigned TIMEOUT_CYC = 100;
   localparam int unsigned GAP_CYC     = 16;
   localparam int unsigned TO_W        = 7;

   logic        clk_50m = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [3:0]  req = 4'd0;
   logic [13:0] Data_O_AD9244 = 14'h2ABC;
   logic [13:0] Data_O_AD9244_1 = 14'h1234;
   logic [27:0] Data_send_FFT = 28'hFEDCBA9;
   logic [27:0] Data_send_FFT_1 = 28'h1234567;
   logic        tx_done = 1'b0;
   logic        err_clr = 1'b0;
   logic [3:0]  ack;
   logic [7:0]  DataTX_1, DataTX_2, DataTX_3, DataTX_4;
   logic        EnTxData;
   logic        busy;
   logic        err_timeout;
`ifdef ADC_TX_STAT_EN
   logic [15:0] frame_cnt;
   logic [7:0]  to_cnt;
`endif

   int n_chk = 0;
   int n_bad = 0;
   int exp_frames = 0;

   adc_tx_scheduler #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .GAP_CYC     (GAP_CYC),
      .TO_W        (TO_W)
   ) dut (
      .clk_50m         (clk_50m),
      .rst             (rst),
      .en              (en),
      .req             (req),
      .Data_O_AD9244   (Data_O_AD9244),
      .Data_O_AD9244_1 (Data_O_AD9244_1),
      .Data_send_FFT   (Data_send_FFT),
      .Data_send_FFT_1 (Data_send_FFT_1),
      .tx_done         (tx_done),
      .err_clr         (err_clr),
      .ack             (ack),
      .DataTX_1        (DataTX_1),
      .DataTX_2        (DataTX_2),
      .DataTX_3        (DataTX_3),
      .DataTX_4        (DataTX_4),
      .EnTxData        (EnTxData),
      .busy            (busy),
`ifdef ADC_TX_STAT_EN
      .frame_cnt       (frame_cnt),
      .to_cnt          (to_cnt),
`endif
      .err_timeout     (err_timeout)
   );

   always #10 clk_50m = ~clk_50m;

   wire [31:0] tx_bytes = {DataTX_1, DataTX_2, DataTX_3, DataTX_4};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic start_frame(input string tag, input logic [3:0] exp_ack, input bit drop);
      int n;
      n = 0;
      while (ack == 4'd0 && n < 50) begin
         tick();
         n++;
      end
      chk({tag, " ack"}, 32'(ack), 32'(exp_ack));
      chk({tag, " en_early"}, 32'(EnTxData), 32'd0);
      if (drop) req = req & ~exp_ack;
      tick();
      chk({tag, " ack_pulse"}, 32'(ack), 32'd0);
      chk({tag, " en_tx"}, 32'(EnTxData), 32'd1);
   endtask

   task automatic finish_frame(input string tag, input logic [31:0] exp_bytes, input int lat,
                               input bit kill_en);
      int n;
      chk({tag, " bytes"}, tx_bytes, exp_bytes);
      for (int i = 0; i < lat; i++) begin
         tick();
         if (kill_en && i == 0) en = 1'b0;
      end
      chk({tag, " bytes_hold"}, tx_bytes, exp_bytes);
      chk({tag, " busy_wait"}, 32'(busy), 32'd1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      exp_frames++;
      n = 1;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk({tag, " gap"}, 32'(n), 32'(GAP_CYC + 1));
`ifdef ADC_TX_STAT_EN
      chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
`endif
      $display("frame %s bytes=%08h idle_after=%0d", tag, tx_bytes, n);
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [3:0] ack_acc;
      logic       busy_acc;

      // Reset state
      tick();
      tick();
      chk("rst ack", 32'(ack), 32'd0);
      chk("rst en_tx", 32'(EnTxData), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst err", 32'(err_timeout), 32'd0);
      chk("rst bytes", tx_bytes, 32'd0);
      rst = 1'b0;

      // Single ADC ch0 frame, tx_done 5 cycles after EnTxData
      req = 4'b0001;
      start_frame("t1", 4'b0001, 1'b1);
      finish_frame("t1", 32'h80002ABC, 5, 1'b0);

      // Fairness from a fresh pointer with all requests held
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_frames = 0;
      req = 4'b1111;
      start_frame("rr0", 4'b0001, 1'b0);
      finish_frame("rr0", 32'h80002ABC, 1, 1'b0);
      start_frame("rr1", 4'b0010, 1'b0);
      finish_frame("rr1", 32'h90001234, 2, 1'b0);
      start_frame("rr2", 4'b0100, 1'b0);
      finish_frame("rr2", 32'hAFEDCBA9, 3, 1'b0);
      start_frame("rr3", 4'b1000, 1'b0);
      finish_frame("rr3", 32'hB1234567, 4, 1'b0);
      start_frame("rr4", 4'b0001, 1'b0);
      req = 4'd0;
      finish_frame("rr4", 32'h80002ABC, 5, 1'b0);

      // Timeout with no tx_done
      req = 4'b0001;
      start_frame("to", 4'b0001, 1'b1);
      chk("to bytes", tx_bytes, 32'h80002ABC);
      tick();
      n = 0;
      while (!err_timeout && n < 300) begin
         tick();
         n++;
      end
      chk("to rise", 32'(n), 32'(TIMEOUT_CYC));
      chk("to busy_gap", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("to gap", 32'(n), 32'(GAP_CYC));
      chk("to sticky", 32'(err_timeout), 32'd1);
`ifdef ADC_TX_STAT_EN
      chk("to to_cnt", 32'(to_cnt), 32'd1);
`endif
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to clr", 32'(err_timeout), 32'd0);
`ifdef ADC_TX_STAT_EN
      chk("to to_cnt_clr", 32'(to_cnt), 32'd0);
`endif
      $display("timeout rise_after=%0d cycles", TIMEOUT_CYC);

      // tx_done on the last timeout cycle counts as success
      req = 4'b0001;
      start_frame("edge", 4'b0001, 1'b1);
      tick();
      for (int i = 1; i < int'(TIMEOUT_CYC); i++) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      exp_frames++;
      chk("edge err", 32'(err_timeout), 32'd0);
      chk("edge busy_gap", 32'(busy), 32'd1);
`ifdef ADC_TX_STAT_EN
      chk("edge frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      chk("edge to_cnt", 32'(to_cnt), 32'd0);
`endif
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("edge gap", 32'(n), 32'(GAP_CYC));
      $display("edge frame done err=%0d", err_timeout);

      // Reset in the middle of WAIT
      req = 4'b0001;
      start_frame("mid", 4'b0001, 1'b1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mid ack", 32'(ack), 32'd0);
      chk("mid en_tx", 32'(EnTxData), 32'd0);
      chk("mid busy", 32'(busy), 32'd0);
      chk("mid err", 32'(err_timeout), 32'd0);
      chk("mid bytes", tx_bytes, 32'd0);
`ifdef ADC_TX_STAT_EN
      chk("mid frame_cnt", 32'(frame_cnt), 32'd0);
`endif
      exp_frames = 0;
      rst = 1'b0;
      req = 4'b0010;
      tx_done = 1'b1;
      start_frame("post", 4'b0010, 1'b1);
      tick();
      tx_done = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("post stray", 32'(busy), 32'd1);
      finish_frame("post", 32'h90001234, 1, 1'b0);

      // en low blocks grants; dropping en mid-WAIT lets the frame finish
      en = 1'b0;
      req = 4'b1111;
      ack_acc = 4'd0;
      busy_acc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         ack_acc |= ack;
         busy_acc |= busy;
      end
      chk("en0 ack", 32'(ack_acc), 32'd0);
      chk("en0 busy", 32'(busy_acc), 32'd0);
      en = 1'b1;
      start_frame("endrop", 4'b0100, 1'b0);
      finish_frame("endrop", 32'hAFEDCBA9, 3, 1'b1);
      ack_acc = 4'd0;
      busy_acc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         ack_acc |= ack;
         busy_acc |= busy;
      end
      chk("endrop no_ack", 32'(ack_acc), 32'd0);
      chk("endrop idle", 32'(busy_acc), 32'd0);
      req = 4'd0;
      en = 1'b1;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
